// File: rtl/jk_register_bank.sv
// Bank of independent JK flip-flops with parallel load,
// change pulses and saturating per-channel change counters.
module jk_register_bank #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   load,
    input  logic [WIDTH-1:0]       d,
    input  logic [WIDTH-1:0]       j,
    input  logic [WIDTH-1:0]       k,
    input  logic                   cnt_clr,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       changed,
    output logic                   any_chg,
    output logic [WIDTH*CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] delta;

    always_comb begin
        q_next = q;
        if (load) begin
            q_next = d;
        end else if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                unique case ({j[i], k[i]})
                    2'b01:   q_next[i] = 1'b0;
                    2'b10:   q_next[i] = 1'b1;
                    2'b11:   q_next[i] = ~q[i];
                    default: q_next[i] = q[i];
                endcase
            end
        end
    end

    assign delta = q_next ^ q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= RESET_VAL;
            changed <= '0;
            any_chg <= 1'b0;
        end else begin
            q       <= q_next;
            changed <= delta;
            any_chg <= |delta;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cnt
        logic [CNT_W-1:0] c;

        // clear beats a same-edge increment; all-ones holds (saturate)
        always_ff @(posedge clk) begin
            if (reset || cnt_clr) begin
                c <= '0;
            end else if (delta[g] && !(&c)) begin
                c <= c + CNT_W'(1);
            end
        end

        assign cnt[g*CNT_W +: CNT_W] = c;
    end

endmodule

// File: tb/tb_jk_register_bank.sv
// Directed + random bench for jk_register_bank;
// expected values queued at drive time, popped after the edge.
module tb_jk_register_bank;

    localparam int         W  = 8;
    localparam int         CW = 2;
    localparam logic [7:0] RV = 8'hA5;

    logic          clk = 1'b0;
    logic          reset, en, load, cnt_clr;
    logic [W-1:0]  d, j, k;
    logic [W-1:0]  q, changed;
    logic          any_chg;
    logic [W*CW-1:0] cnt;

    jk_register_bank #(
        .WIDTH(W), .CNT_W(CW), .RESET_VAL(RV)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .load(load),
        .d(d), .j(j), .k(k), .cnt_clr(cnt_clr),
        .q(q), .changed(changed), .any_chg(any_chg), .cnt(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]    q;
        logic [W-1:0]    chg;
        logic            any;
        logic [W*CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    int nvec = 0;
    int nerr = 0;

    logic [W-1:0]    mq;
    logic [W*CW-1:0] mcnt;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic rs, input logic ld,
                         input logic e, input logic cc,
                         input logic [W-1:0] dd,
                         input logic [W-1:0] jj,
                         input logic [W-1:0] kk);
        exp_t x;
        logic [W-1:0] nq;
        logic [CW-1:0] c;
        reset = rs; load = ld; en = e; cnt_clr = cc;
        d = dd; j = jj; k = kk;
        nq = mq;
        if (rs) nq = RV;
        else if (ld) nq = dd;
        else if (e) begin
            for (int i = 0; i < W; i++) begin
                if (jj[i] && kk[i]) nq[i] = ~mq[i];
                else if (jj[i]) nq[i] = 1'b1;
                else if (kk[i]) nq[i] = 1'b0;
            end
        end
        x.q   = nq;
        x.chg = rs ? '0 : (nq ^ mq);
        x.any = |x.chg;
        for (int i = 0; i < W; i++) begin
            c = mcnt[i*CW +: CW];
            if (rs || cc) c = '0;
            else if (x.chg[i] && c != '1) c = c + 1'b1;
            mcnt[i*CW +: CW] = c;
        end
        x.cnt = mcnt;
        mq = nq;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("q", 32'(q), 32'(x.q));
        check("changed", 32'(changed), 32'(x.chg));
        check("any_chg", 32'(any_chg), 32'(x.any));
        check("cnt", 32'(cnt), 32'(x.cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        mq = 'x; mcnt = 'x;
        // reset two cycles
        apply(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        apply(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        check("rst_q_const", 32'(q), 32'h000000A5);
        check("rst_cnt_const", 32'(cnt), 32'h0);
        // load zero and clear counters, then toggle 3x
        apply(0, 1, 0, 1, 8'h00, 8'h00, 8'h00);
        check("clr_cnt_const", 32'(cnt), 32'h0);
        repeat (3) apply(0, 0, 1, 0, 8'h00, 8'hFF, 8'hFF);
        check("tog_q_const", 32'(q), 32'h000000FF);
        check("tog_cnt_const", 32'(cnt), 32'h0000FFFF);
        // en low ignores JK; then load wins over toggle
        apply(0, 0, 0, 0, 8'h00, 8'h0F, 8'hF0);
        apply(0, 1, 1, 0, 8'h3C, 8'hFF, 8'hFF);
        check("ld_chg_const", 32'(changed), 32'h000000C3);
        // saturation of bit0 counter
        apply(0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
        repeat (5) apply(0, 0, 1, 0, 8'h00, 8'h01, 8'h01);
        check("sat_cnt0_const", 32'(cnt[1:0]), 32'h3);
        apply(0, 0, 1, 1, 8'h00, 8'h01, 8'h01);
        check("clr_tog_cnt0", 32'(cnt[1:0]), 32'h0);
        check("clr_tog_chg0", 32'(changed[0]), 32'h1);
        // per-bit modes from zero
        apply(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
        apply(0, 0, 1, 0, 8'h00, 8'b0000_0110, 8'b0000_0011);
        check("modes_q_const", 32'(q), 32'h06);
        // reset beats load
        apply(1, 1, 1, 0, 8'hFF, 8'hFF, 8'hFF);
        check("rst_ld_q", 32'(q), 32'(RV));
        // random traffic
        for (int n = 0; n < 60; n++) begin
            apply(($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 4) == 0),
                  1'($urandom), ($urandom_range(0, 9) == 0),
                  8'($urandom), 8'($urandom), 8'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
